// File: rtl/pipelined_add_accum_pkg.sv
// Shared types and default widths for the pipelined add/accumulate block.
// Operation codes travel with each operand pair and select the datapath result.
package pipelined_add_accum_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_ACC_WIDTH = 16;
  localparam int unsigned DEF_CNT_WIDTH = 8;
  localparam bit          DEF_SATURATE  = 1'b1;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/sat_adder.sv
// Combinational three-operand adder with a (W+1)-bit internal sum, overflow
// detection and optional clamp to all-ones.
module sat_adder #(
  parameter int unsigned W        = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] op_c,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full_sum;

  // One extra bit is enough because callers keep op_b + op_c well below 2^W.
  assign full_sum = {1'b0, op_a} + {1'b0, op_b} + {1'b0, op_c};
  assign ovf      = full_sum[W];
  assign sum      = (SATURATE && ovf) ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: rtl/pipelined_add_accum.sv
// Operand-pair adder/subtractor/accumulator with a one-deep registered
// valid/ready output stage, sticky overflow flag and accepted-pair counter.
module pipelined_add_accum
  import pipelined_add_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter bit          SATURATE  = DEF_SATURATE,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  input  logic                 clr_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_flag,
  output logic                 ovf_sticky,
  output logic [CNT_WIDTH-1:0] txn_count
);

  logic                 out_valid_q,  out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q,   out_data_d;
  logic                 out_flag_q,   out_flag_d;
  logic [ACC_WIDTH-1:0] acc_q,        acc_d;
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic [CNT_WIDTH-1:0] txn_count_q,  txn_count_d;

  mode_t                mode;
  logic                 accept;
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic [ACC_WIDTH-1:0] sub_diff;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_ovf;

  // The output register frees up in the same cycle it is drained.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign mode     = mode_t'(in_mode);

  assign a_ext    = ACC_WIDTH'(in_a);
  assign b_ext    = ACC_WIDTH'(in_b);
  assign add_sum  = a_ext + b_ext;
  assign sub_diff = a_ext - b_ext;

  sat_adder #(
    .W        (ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_acc_adder (
    .op_a (acc_q),
    .op_b (a_ext),
    .op_c (b_ext),
    .sum  (acc_sum),
    .ovf  (acc_ovf)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_flag_d   = out_flag_q;
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;
    txn_count_d  = txn_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr_ovf) begin
      ovf_sticky_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      txn_count_d = txn_count_q + CNT_WIDTH'(1);
      unique case (mode)
        MODE_ADD: begin
          out_data_d = add_sum;
          out_flag_d = add_sum[WIDTH];
        end
        MODE_SUB: begin
          out_data_d = sub_diff;
          out_flag_d = (in_b > in_a);
        end
        MODE_ACC: begin
          out_data_d = acc_sum;
          out_flag_d = acc_ovf;
          acc_d      = acc_sum;
          // A new overflow outranks a simultaneous clear.
          if (acc_ovf) begin
            ovf_sticky_d = 1'b1;
          end
        end
        MODE_LOAD: begin
          out_data_d = add_sum;
          out_flag_d = 1'b0;
          acc_d      = add_sum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every register samples
    // its _d from the same pre-edge values.
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_flag_q   <= 1'b0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
      txn_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flag_q   <= out_flag_d;
      acc_q        <= acc_d;
      ovf_sticky_q <= ovf_sticky_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_flag   = out_flag_q;
  assign ovf_sticky = ovf_sticky_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_pipelined_add_accum.sv
// Self-checking bench: table-driven vectors plus hand-written sequences, with
// a result scoreboard filled at accept time and drained by an output monitor.
module tb_pipelined_add_accum;
  import pipelined_add_accum_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_mode;
  logic        clr_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_flag;
  logic        ovf_sticky;
  logic [7:0]  txn_count;

  pipelined_add_accum #(
    .WIDTH     (8),
    .ACC_WIDTH (16),
    .SATURATE  (1'b1),
    .CNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .clr_ovf    (clr_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flag   (out_flag),
    .ovf_sticky (ovf_sticky),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    mode_t       mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        flag;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        flag;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  logic [15:0] acc_m;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted pair; updates the model accumulator.
  function automatic void model(input mode_t m, input logic [7:0] a, input logic [7:0] b,
                                output logic [15:0] d, output logic f);
    logic [16:0] s;
    case (m)
      MODE_ADD: begin
        s = 17'(a) + 17'(b);
        d = s[15:0];
        f = s[8];
      end
      MODE_SUB: begin
        d = 16'(a) - 16'(b);
        f = (b > a);
      end
      MODE_ACC: begin
        s = 17'(acc_m) + 17'(a) + 17'(b);
        f = s[16];
        d = f ? 16'hFFFF : s[15:0];
        acc_m = d;
      end
      default: begin
        d = 16'(a) + 16'(b);
        f = 1'b0;
        acc_m = d;
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input mode_t m, input logic [7:0] a, input logic [7:0] b,
                      input logic clr, input logic [15:0] ed, input logic ef);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    clr_ovf  = clr;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.data = ed;
      e.flag = ef;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic send_model(input mode_t m, input logic [7:0] a, input logic [7:0] b,
                            input logic clr);
    logic [15:0] d;
    logic        f;
    model(m, a, b, d, f);
    send(m, a, b, clr, d, f);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got data 0x%0h, expected no result", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_flag", 32'(out_flag), 32'(e.flag));
      end
    end
  end

  initial begin
    logic [7:0]  cnt_saved;
    logic [15:0] d_dummy;
    logic        f_dummy;
    int          t0;

    vecs[0]  = '{MODE_ADD,  8'd200, 8'd100, 16'd300,   1'b1};
    vecs[1]  = '{MODE_SUB,  8'd5,   8'd9,   16'hFFFC,  1'b1};
    vecs[2]  = '{MODE_SUB,  8'd9,   8'd5,   16'd4,     1'b0};
    vecs[3]  = '{MODE_ACC,  8'd0,   8'd0,   16'd0,     1'b0};
    vecs[4]  = '{MODE_ADD,  8'd255, 8'd255, 16'd510,   1'b1};
    vecs[5]  = '{MODE_ADD,  8'd1,   8'd2,   16'd3,     1'b0};
    vecs[6]  = '{MODE_LOAD, 8'd255, 8'd255, 16'd510,   1'b0};
    vecs[7]  = '{MODE_ACC,  8'd255, 8'd255, 16'd1020,  1'b0};
    vecs[8]  = '{MODE_ACC,  8'd255, 8'd255, 16'd1530,  1'b0};
    vecs[9]  = '{MODE_SUB,  8'd0,   8'd255, 16'hFF01,  1'b1};
    vecs[10] = '{MODE_ACC,  8'd255, 8'd255, 16'd2040,  1'b0};
    vecs[11] = '{MODE_LOAD, 8'd0,   8'd0,   16'd0,     1'b0};
    vecs[12] = '{MODE_ACC,  8'd128, 8'd127, 16'd255,   1'b0};

    acc_m     = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = '0;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_out_data",   32'(out_data),   32'd0);
    check("reset_out_flag",   32'(out_flag),   32'd0);
    check("reset_ovf_sticky", 32'(ovf_sticky), 32'd0);
    check("reset_txn_count",  32'(txn_count),  32'd0);
    check("reset_in_ready",   32'(in_ready),   32'd1);

    // Single ADD: result and count appear the cycle after accept.
    step();
    model(MODE_ADD, 8'd200, 8'd100, d_dummy, f_dummy);
    send(MODE_ADD, 8'd200, 8'd100, 1'b0, 16'd300, 1'b1);
    @(negedge clk);
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_txn_count", 32'(txn_count), 32'd1);
    step();

    for (int i = 0; i < 13; i++) begin
      model(vecs[i].mode, vecs[i].a, vecs[i].b, d_dummy, f_dummy);
      send(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0, vecs[i].data, vecs[i].flag);
    end
    drain();
    check("table_txn_count", 32'(txn_count), 32'd14);

    // Saturation: 510 + 128 * 510 crosses 2^16 on the 128th ACC.
    step();
    send_model(MODE_LOAD, 8'hFF, 8'hFF, 1'b0);
    for (int k = 1; k <= 128; k++) begin
      send_model(MODE_ACC, 8'hFF, 8'hFF, 1'b0);
    end
    @(negedge clk);
    check("sat_out_data",   32'(out_data),   32'hFFFF);
    check("sat_out_flag",   32'(out_flag),   32'd1);
    check("sat_ovf_sticky", 32'(ovf_sticky), 32'd1);
    step();

    send_model(MODE_ACC, 8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    check("sticky_set_beats_clear", 32'(ovf_sticky), 32'd1);
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 32'(ovf_sticky), 32'd0);
    drain();

    // Backpressure: held result, no accept, frozen counter.
    step();
    out_ready = 1'b0;
    send_model(MODE_ADD, 8'd10, 8'd20, 1'b0);
    cnt_saved = txn_count;
    in_valid  = 1'b1;
    in_a      = 8'd7;
    in_b      = 8'd8;
    in_mode   = MODE_ADD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_data",  32'(out_data),  32'd30);
      check("bp_txn_count", 32'(txn_count), 32'(cnt_saved));
    end
    step();
    out_ready = 1'b1;
    send_model(MODE_ADD, 8'd7, 8'd8, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_model(mode_t'(k % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end
    drain();

    // Reset with a pending, stalled result and the sticky flag set.
    step();
    send_model(MODE_ACC, 8'd1, 8'd1, 1'b0);
    @(negedge clk);
    check("pre_reset_sticky", 32'(ovf_sticky), 32'd1);
    step();
    out_ready = 1'b0;
    send_model(MODE_ADD, 8'd3, 8'd4, 1'b0);
    @(negedge clk);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
    acc_m     = '0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_reset_out_valid",  32'(out_valid),  32'd0);
    check("mid_reset_txn_count",  32'(txn_count),  32'd0);
    check("mid_reset_ovf_sticky", 32'(ovf_sticky), 32'd0);
    step();
    model(MODE_ACC, 8'd0, 8'd0, d_dummy, f_dummy);
    send(MODE_ACC, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0);

    // 255 more pairs make 256 accepts since reset: the counter wraps to 0.
    t0 = cyc;
    for (int k = 0; k < 255; k++) begin
      send_model(mode_t'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'b0);
    end
    check("stream_throughput_cycles", 32'(cyc - t0), 32'd255);
    drain();
    check("wrap_txn_count", 32'(txn_count), 32'd0);
    step();
    model(MODE_ACC, 8'd0, 8'd0, d_dummy, f_dummy);
    send(MODE_ACC, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
